// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV32 decode constants: base opcodes, default data
//                width, immediate-format classification and its helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5
    } imm_fmt_e;

    // Maps a base opcode to the layout of its immediate field. R-type and
    // any unrecognised opcode carry no immediate.
    function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
        case (op)
            OP_IMM, OP_LOAD, OP_JALR: return FMT_I;
            OP_STORE:                 return FMT_S;
            OP_BRANCH:                return FMT_B;
            OP_LUI, OP_AUIPC:         return FMT_U;
            OP_JAL:                   return FMT_J;
            default:                  return FMT_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_if
//  Description : Writeback bus into the decode stage register file.
//                master : writeback stage (drives the write)
//                slave  : decode stage (consumes the write)
//  Signals     : reg_write  - write enable
//                write_reg  - destination register index
//                write_data - data to write
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_stage_if #(
    parameter int XLEN = 32
);
    logic            reg_write;
    logic [4:0]      write_reg;
    logic [XLEN-1:0] write_data;

    modport master (output reg_write, output write_reg, output write_data);
    modport slave  (input  reg_write, input  write_reg, input  write_data);
endinterface
`default_nettype wire

// File: rtl/id_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : id_regfile
//  Description : Architectural register file, 2 asynchronous read ports and
//                1 synchronous write port. x0 is hard-wired to zero. All
//                entries clear asynchronously while rst_n is low, and reads
//                return zero during reset.
//  Config      : ID_BYPASS_EN - when defined, a write in flight to a
//                non-zero register is forwarded to a read port addressing
//                the same register in the same cycle.
//  Ports       : clk, rst_n            - clock, async active-low reset
//                i_we/i_waddr/i_wdata  - write port
//                i_raddr1/o_rdata1     - read port 1
//                i_raddr2/o_rdata2     - read port 2
//  Revision    : 1.0 - initial release
// ============================================================================
module id_regfile #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr1,
    input  logic [4:0]      i_raddr2,
    output logic [XLEN-1:0] o_rdata1,
    output logic [XLEN-1:0] o_rdata2
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [XLEN-1:0] w_rf1;
    logic [XLEN-1:0] w_rf2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != 5'd0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign w_rf1 = (i_raddr1 == 5'd0) ? '0 : r_regs[i_raddr1];
    assign w_rf2 = (i_raddr2 == 5'd0) ? '0 : r_regs[i_raddr2];

`ifdef ID_BYPASS_EN
    logic w_byp1;
    logic w_byp2;

    assign w_byp1 = i_we && (i_waddr != 5'd0) && (i_waddr == i_raddr1);
    assign w_byp2 = i_we && (i_waddr != 5'd0) && (i_waddr == i_raddr2);

    // Reset dominates the forward path so reads are zero throughout reset.
    assign o_rdata1 = !rst_n ? '0 : (w_byp1 ? i_wdata : w_rf1);
    assign o_rdata2 = !rst_n ? '0 : (w_byp2 ? i_wdata : w_rf2);
`else
    assign o_rdata1 = !rst_n ? '0 : w_rf1;
    assign o_rdata2 = !rst_n ? '0 : w_rf2;
`endif

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : RV32 instruction decode stage. Purely combinational field
//                extraction and immediate generation, plus the register file
//                that supplies the source operands. No pipeline register.
//  Config      : ID_BYPASS_EN - forward same-cycle writeback data to the
//                operands (handled inside id_regfile).
//  Ports       : clk, rst_n           - clock, async active-low reset
//                instruction          - instruction word being decoded
//                wb (slave)           - writeback bus into the register file
//                rs1, rs2, rd         - decoded register indices
//                operand1, operand2   - RF[rs1], RF[rs2]
//                opcode/funct3/funct7 - raw instruction fields
//                imm                  - sign-extended immediate
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     instruction,
    id_stage_if.slave       wb,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [XLEN-1:0] operand1,
    output logic [XLEN-1:0] operand2,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm
);

    imm_fmt_e    w_fmt;
    logic [31:0] w_imm32;

    // Field extraction is identical for every opcode; consumers ignore the
    // fields that do not apply.
    assign rs1    = instruction[19:15];
    assign rs2    = instruction[24:20];
    assign rd     = instruction[11:7];
    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    assign w_fmt = imm_fmt(instruction[6:0]);

    always_comb begin
        w_imm32 = '0;
        case (w_fmt)
            FMT_I: w_imm32 = {{20{instruction[31]}}, instruction[31:20]};
            FMT_S: w_imm32 = {{20{instruction[31]}}, instruction[31:25],
                              instruction[11:7]};
            FMT_B: w_imm32 = {{19{instruction[31]}}, instruction[31],
                              instruction[7], instruction[30:25],
                              instruction[11:8], 1'b0};
            FMT_U: w_imm32 = {instruction[31:12], 12'b0};
            FMT_J: w_imm32 = {{11{instruction[31]}}, instruction[31],
                              instruction[19:12], instruction[20],
                              instruction[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    // The 32-bit immediate is already sign-extended from bit 31; widen to
    // XLEN by continuing that sign.
    assign imm = XLEN'($signed(w_imm32));

    id_regfile #(
        .XLEN (XLEN),
        .NREG (NREG)
    ) u_regfile (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_we     (wb.reg_write),
        .i_waddr  (wb.write_reg),
        .i_wdata  (wb.write_data),
        .i_raddr1 (instruction[19:15]),
        .i_raddr2 (instruction[24:20]),
        .o_rdata1 (operand1),
        .o_rdata2 (operand2)
    );

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Self-checking bench for id_stage: directed decode, register
//                file, x0, reset and forwarding scenarios followed by
//                randomized instructions and writes checked against a
//                behavioural model. ID_BYPASS_EN selects the forwarding
//                expectation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    logic        clk;
    logic        rst_n;
    logic [31:0] instruction;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] operand1, operand2;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [32];

    id_stage_if #(.XLEN(32)) wb ();

    id_stage #(.XLEN(32), .NREG(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instruction (instruction),
        .wb          (wb.slave),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .operand1    (operand1),
        .operand2    (operand2),
        .opcode      (opcode),
        .funct3      (funct3),
        .funct7      (funct7),
        .imm         (imm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge; the model takes the write only outside reset and
    // never for x0. Inputs change 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n && wb.reg_write && wb.write_reg != 5'd0)
            model[wb.write_reg] = wb.write_data;
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
    endtask

    function automatic logic [31:0] exp_op(input logic [4:0] idx);
        if (!rst_n) return 32'd0;
        if (idx == 5'd0) return 32'd0;
`ifdef ID_BYPASS_EN
        if (wb.reg_write && wb.write_reg == idx) return wb.write_data;
`endif
        return model[idx];
    endfunction

    // Immediate value computed arithmetically from the format's bit fields.
    function automatic logic [31:0] ref_imm(input logic [31:0] ins);
        int v;
        v = 0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67: begin
                v = int'(ins[31:20]);
                if (v >= 2048) v -= 4096;
            end
            7'h23: begin
                v = int'(ins[31:25]) * 32 + int'(ins[11:7]);
                if (v >= 2048) v -= 4096;
            end
            7'h63: begin
                v = int'(ins[31]) * 4096 + int'(ins[7]) * 2048 +
                    int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
                if (v >= 4096) v -= 8192;
            end
            7'h37, 7'h17: return ins & 32'hFFFF_F000;
            7'h6F: begin
                v = int'(ins[31]) * (1 << 20) + int'(ins[19:12]) * (1 << 12) +
                    int'(ins[20]) * (1 << 11) + int'(ins[30:21]) * 2;
                if (v >= (1 << 20)) v -= (1 << 21);
            end
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".rs1"},    32'(rs1),      32'(instruction[19:15]));
        chk({tag, ".rs2"},    32'(rs2),      32'(instruction[24:20]));
        chk({tag, ".rd"},     32'(rd),       32'(instruction[11:7]));
        chk({tag, ".opcode"}, 32'(opcode),   32'(instruction[6:0]));
        chk({tag, ".funct3"}, 32'(funct3),   32'(instruction[14:12]));
        chk({tag, ".funct7"}, 32'(funct7),   32'(instruction[31:25]));
        chk({tag, ".imm"},    imm,           ref_imm(instruction));
        chk({tag, ".op1"},    operand1,      exp_op(instruction[19:15]));
        chk({tag, ".op2"},    operand2,      exp_op(instruction[24:20]));
    endtask

    logic [6:0] ops [10];

    initial begin
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};
        clear_model();

        // Reset state; decode fields stay live while in reset.
        rst_n          = 1'b0;
        wb.reg_write   = 1'b0;
        wb.write_reg   = 5'd0;
        wb.write_data  = 32'd0;
        instruction    = 32'h0020_81B3;
        #2;
        chk("rst.rs1", 32'(rs1), 32'd1);
        chk("rst.rd",  32'(rd),  32'd3);
        chk("rst.op1", operand1, 32'd0);
        chk("rst.op2", operand2, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // x1 = 10, x2 = 20 on successive edges.
        wb.reg_write = 1'b1; wb.write_reg = 5'd1; wb.write_data = 32'd10;
        tick();
        wb.write_reg = 5'd2; wb.write_data = 32'd20;
        tick();
        wb.reg_write = 1'b0;
        #2;
        instruction = 32'h0020_81B3;
        #1;
        chk("add.rs1", 32'(rs1), 32'd1);
        chk("add.rs2", 32'(rs2), 32'd2);
        chk("add.rd",  32'(rd),  32'd3);
        chk("add.op1", operand1, 32'h0000_000A);
        chk("add.op2", operand2, 32'h0000_0014);
        chk("add.imm", imm,      32'd0);

        instruction = 32'h0011_01B3;
        #1;
        chk("swap.rs1", 32'(rs1), 32'd2);
        chk("swap.rs2", 32'(rs2), 32'd1);
        chk("swap.op1", operand1, 32'h0000_0014);
        chk("swap.op2", operand2, 32'h0000_000A);

        // Writes to x0 are discarded.
        tick();
        wb.reg_write = 1'b1; wb.write_reg = 5'd0; wb.write_data = 32'hDEAD_BEEF;
        tick();
        wb.reg_write = 1'b0;
        instruction = 32'h0000_0033;
        #1;
        chk("x0.op1", operand1, 32'd0);
        chk("x0.op2", operand2, 32'd0);

        // Immediates.
        instruction = 32'hFFF0_0293;
        #1;
        chk("addi.imm",    imm,         32'hFFFF_FFFF);
        chk("addi.rd",     32'(rd),     32'd5);
        chk("addi.funct3", 32'(funct3), 32'd0);
        instruction = 32'h1234_52B7;
        #1;
        chk("lui.imm", imm, 32'h1234_5000);

        // Same-cycle write and read of x4.
        tick();
        instruction = 32'h0002_0033;
        wb.reg_write = 1'b1; wb.write_reg = 5'd4; wb.write_data = 32'd7;
        #1;
`ifdef ID_BYPASS_EN
        chk("byp.pre", operand1, 32'd7);
`else
        chk("byp.pre", operand1, 32'd0);
`endif
        tick();
        wb.reg_write = 1'b0;
        #1;
        chk("byp.post", operand1, 32'd7);

        // Asynchronous reset between edges clears x1 immediately.
        instruction = 32'h0020_81B3;
        #1;
        chk("arst.pre", operand1, 32'd10);
        rst_n = 1'b0;
        #1;
        chk("arst.low", operand1, 32'd0);
        rst_n = 1'b1;
        clear_model();
        #1;
        chk("arst.rel", operand1, 32'd0);

        // A write coinciding with an edge while in reset is lost.
        tick();
        wb.reg_write = 1'b1; wb.write_reg = 5'd1; wb.write_data = 32'd55;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        wb.reg_write = 1'b0;
        #1;
        chk("rstwr.op1", operand1, 32'd0);

        // Randomized instructions and writes against the model.
        for (int n = 0; n < 300; n++) begin
            instruction   = {$urandom()} & 32'hFFFF_FF80;
            instruction[6:0] = ops[$urandom_range(0, 9)];
            wb.reg_write  = ($urandom_range(0, 3) != 0);
            wb.write_reg  = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) wb.write_reg = instruction[19:15];
            wb.write_data = $urandom();
            #2;
            check_all("rnd");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
